// File: rtl/cpu_writeback.sv
// cpu_writeback: initiator side of the tag-change register-file write port.
// Retired results from the execute and load units are queued in a small
// in-order FIFO. One entry is drained per edge by presenting its rd index
// and value and then bumping o_write_tag. The register file commits on
// every tag change it sees.
// Optional feature: define WRITEBACK_FORWARD_EN to add a combinational
// forwarding lookup over queued and just-issued writes.
module cpu_writeback #(
  parameter int DEPTH     = 4,
  parameter int TAG_WIDTH = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_ex_valid,
  output logic                 o_ex_ready,
  input  logic [4:0]           i_ex_rd_idx,
  input  logic [31:0]          i_ex_rd,
  input  logic                 i_mem_valid,
  output logic                 o_mem_ready,
  input  logic [4:0]           i_mem_rd_idx,
  input  logic [31:0]          i_mem_rd,
`ifdef WRITEBACK_FORWARD_EN
  input  logic [4:0]           i_fwd_rs_idx,
  output logic                 o_fwd_hit,
  output logic [31:0]          o_fwd_value,
`endif
  output logic [TAG_WIDTH-1:0] o_write_tag,
  output logic [4:0]           o_write_rd_idx,
  output logic [31:0]          o_rd,
  output logic                 o_busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // FIFO storage and bookkeeping
  logic [4:0]           r_fifo_idx  [DEPTH];
  logic [31:0]          r_fifo_data [DEPTH];
  logic [CNT_W-1:0]     r_count;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W-1:0]     r_wr_ptr;

  // Registered write-port outputs
  logic [TAG_WIDTH-1:0] r_write_tag;
  logic [4:0]           r_write_rd_idx;
  logic [31:0]          r_rd;
  logic                 r_busy;

  logic                 w_pop;
  logic                 w_mem_push;
  logic                 w_ex_push;
  logic [PTR_W-1:0]     w_ex_wr_ptr;
  logic [CNT_W-1:0]     w_count_next;

  // Readiness looks only at the registered count; a same-cycle pop is not
  // credited, and the load unit gets the last free slot.
  assign o_mem_ready = (r_count < CNT_W'(DEPTH));
  assign o_ex_ready  = i_mem_valid ? (r_count < CNT_W'(DEPTH - 1))
                                   : (r_count < CNT_W'(DEPTH));

  // Writes to x0 are acknowledged but never occupy a slot.
  assign w_mem_push  = i_mem_valid & o_mem_ready & (i_mem_rd_idx != 5'd0);
  assign w_ex_push   = i_ex_valid  & o_ex_ready  & (i_ex_rd_idx  != 5'd0);
  assign w_pop       = (r_count != '0);

  // The load entry is older than the execute entry accepted alongside it.
  assign w_ex_wr_ptr = r_wr_ptr + PTR_W'(w_mem_push);

  assign w_count_next = r_count + CNT_W'(w_mem_push) + CNT_W'(w_ex_push)
                        - CNT_W'(w_pop);

  // FIFO payload storage, written at the tail on accepted nonzero entries
  // NOTE: the payload array has no reset; r_count alone decides which slots
  // are meaningful, so clearing the data would only add reset fan-out.
  always_ff @(posedge i_clock) begin
    if (w_mem_push) begin
      r_fifo_idx[r_wr_ptr]     <= i_mem_rd_idx;
      r_fifo_data[r_wr_ptr]    <= i_mem_rd;
    end
    if (w_ex_push) begin
      r_fifo_idx[w_ex_wr_ptr]  <= i_ex_rd_idx;
      r_fifo_data[w_ex_wr_ptr] <= i_ex_rd;
    end
  end

  // Pointer/count update and head issue with tag advance
  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values of its peers, matching the hardware's parallel update.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count        <= '0;
      r_rd_ptr       <= '0;
      r_wr_ptr       <= '0;
      r_write_tag    <= '0;
      r_write_rd_idx <= '0;
      r_rd           <= '0;
      r_busy         <= 1'b0;
    end else begin
      r_count  <= w_count_next;
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_mem_push) + PTR_W'(w_ex_push);
      if (w_pop) begin
        r_write_rd_idx <= r_fifo_idx[r_rd_ptr];
        r_rd           <= r_fifo_data[r_rd_ptr];
        r_write_tag    <= r_write_tag + 1'b1;
        r_rd_ptr       <= r_rd_ptr + 1'b1;
      end
      // Busy stays high through the register file's commit cycle.
      r_busy <= (w_count_next != '0) | w_pop;
    end
  end

  assign o_write_tag    = r_write_tag;
  assign o_write_rd_idx = r_write_rd_idx;
  assign o_rd           = r_rd;
  assign o_busy         = r_busy;

`ifdef WRITEBACK_FORWARD_EN
  logic r_fwd_pending;

  // Remembers that the presented write is still awaiting its commit edge
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_fwd_pending <= 1'b0;
    else         r_fwd_pending <= w_pop;
  end

  // Youngest-match search: the issued entry is the oldest candidate, then
  // FIFO slots from head to tail, each later hit overriding earlier ones.
  // NOTE: both outputs get a default before any conditional so no path
  // leaves them unassigned and no latch is inferred.
  always_comb begin
    logic [PTR_W-1:0] v_slot;
    o_fwd_hit   = 1'b0;
    o_fwd_value = '0;
    v_slot      = r_rd_ptr;
    if (r_fwd_pending && (r_write_rd_idx == i_fwd_rs_idx)) begin
      o_fwd_hit   = 1'b1;
      o_fwd_value = r_rd;
    end
    for (int i = 0; i < DEPTH; i++) begin
      v_slot = r_rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < r_count) && (r_fifo_idx[v_slot] == i_fwd_rs_idx)) begin
        o_fwd_hit   = 1'b1;
        o_fwd_value = r_fifo_data[v_slot];
      end
    end
    if (i_fwd_rs_idx == 5'd0) begin
      o_fwd_hit   = 1'b0;
      o_fwd_value = '0;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_writeback.sv
// Self-checking bench for cpu_writeback: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_cpu_writeback;

  localparam int DEPTH = 4;
  localparam int TW    = 8;

  logic          i_clock = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_ex_valid = 1'b0, i_mem_valid = 1'b0;
  logic [4:0]    i_ex_rd_idx = '0, i_mem_rd_idx = '0;
  logic [31:0]   i_ex_rd = '0, i_mem_rd = '0;
  logic          o_ex_ready, o_mem_ready, o_busy;
  logic [TW-1:0] o_write_tag;
  logic [4:0]    o_write_rd_idx;
  logic [31:0]   o_rd;
`ifdef WRITEBACK_FORWARD_EN
  logic [4:0]    i_fwd_rs_idx = '0;
  logic          o_fwd_hit;
  logic [31:0]   o_fwd_value;
`endif

  cpu_writeback #(.DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_ex_valid     (i_ex_valid),
    .o_ex_ready     (o_ex_ready),
    .i_ex_rd_idx    (i_ex_rd_idx),
    .i_ex_rd        (i_ex_rd),
    .i_mem_valid    (i_mem_valid),
    .o_mem_ready    (o_mem_ready),
    .i_mem_rd_idx   (i_mem_rd_idx),
    .i_mem_rd       (i_mem_rd),
`ifdef WRITEBACK_FORWARD_EN
    .i_fwd_rs_idx   (i_fwd_rs_idx),
    .o_fwd_hit      (o_fwd_hit),
    .o_fwd_value    (o_fwd_value),
`endif
    .o_write_tag    (o_write_tag),
    .o_write_rd_idx (o_write_rd_idx),
    .o_rd           (o_rd),
    .o_busy         (o_busy)
  );

  always #5 i_clock = ~i_clock;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of pending writes plus the port state.
  typedef struct { logic [4:0] idx; logic [31:0] val; } ent_t;
  ent_t        q[$];
  int          m_tag;
  logic [4:0]  m_idx;
  logic [31:0] m_rd;
  bit          m_busy, m_pend;

  task automatic check_port(input string where);
    check({where, ".tag"},  o_write_tag,    m_tag);
    check({where, ".idx"},  o_write_rd_idx, m_idx);
    check({where, ".rd"},   o_rd,           m_rd);
    check({where, ".busy"}, o_busy,         m_busy);
  endtask

  // Assert reset between edges, verify the immediate effect, release later.
  task automatic do_reset();
    @(negedge i_clock);
    i_ex_valid = 1'b0; i_mem_valid = 1'b0;
    #2 i_reset = 1'b1;
    #1;
    q.delete(); m_tag = 0; m_idx = '0; m_rd = '0; m_busy = 1'b0; m_pend = 1'b0;
    check_port("reset");
    check("reset.mem_ready", o_mem_ready, 1);
    check("reset.ex_ready",  o_ex_ready,  1);
`ifdef WRITEBACK_FORWARD_EN
    check("reset.fwd_hit", o_fwd_hit, 0);
`endif
    @(posedge i_clock);
    @(negedge i_clock);
    i_reset = 1'b0;
  endtask

  // One clock: drive at the falling edge, check readiness, then model the
  // rising edge and check the registered outputs shortly after it.
  task automatic step(input bit mv, input logic [4:0] mi, input logic [31:0] md,
                      input bit ev, input logic [4:0] ei, input logic [31:0] ed,
                      input logic [4:0] rs);
    bit   mr, er;
    ent_t h;
    @(negedge i_clock);
    i_mem_valid = mv; i_mem_rd_idx = mi; i_mem_rd = md;
    i_ex_valid  = ev; i_ex_rd_idx  = ei; i_ex_rd  = ed;
`ifdef WRITEBACK_FORWARD_EN
    i_fwd_rs_idx = rs;
`endif
    #1;
    mr = (q.size() < DEPTH);
    er = mv ? (q.size() < DEPTH - 1) : (q.size() < DEPTH);
    check("mem_ready", o_mem_ready, mr);
    check("ex_ready",  o_ex_ready,  er);
`ifdef WRITEBACK_FORWARD_EN
    begin
      bit          hh;
      logic [31:0] vv;
      hh = 1'b0; vv = '0;
      if (m_pend && m_idx == rs) begin hh = 1'b1; vv = m_rd; end
      foreach (q[k]) if (q[k].idx == rs) begin hh = 1'b1; vv = q[k].val; end
      if (rs == 5'd0) begin hh = 1'b0; vv = '0; end
      check("fwd_hit",   o_fwd_hit,   hh);
      check("fwd_value", o_fwd_value, vv);
    end
`else
    if (rs != 5'd0) begin end
`endif
    @(posedge i_clock);
    m_pend = 1'b0;
    if (q.size() > 0) begin
      h      = q.pop_front();
      m_idx  = h.idx;
      m_rd   = h.val;
      m_tag  = (m_tag + 1) % (1 << TW);
      m_pend = 1'b1;
    end
    if (mv && mr && mi != 5'd0) q.push_back('{mi, md});
    if (ev && er && ei != 5'd0) q.push_back('{ei, ed});
    m_busy = (q.size() > 0) || m_pend;
    #1 check_port("edge");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    do_reset();

    // Single execute result: issues one edge after accept.
    step(0, 0, 0, 1, 5'd5, 32'hDEAD_BEEF, 0);
    step(0, 0, 0, 0, 0, 0, 5'd5);
    check("single.tag", o_write_tag, 1);
    check("single.rd",  o_rd,        32'hDEAD_BEEF);
    idle(2);

    // Same-cycle load and execute to the same rd: load first.
    step(1, 5'd3, 32'h11, 1, 5'd3, 32'h22, 0);
    step(0, 0, 0, 0, 0, 0, 5'd3);
    check("order.first", o_rd, 32'h11);
    step(0, 0, 0, 0, 0, 0, 5'd3);
    check("order.second", o_rd, 32'h22);
    idle(2);

    // Write to x0: acknowledged, no slot, no tag change.
    step(0, 0, 0, 1, 5'd0, 32'h1234, 0);
    idle(2);
    check("x0.busy", o_busy, 0);

    // Back-to-back pairs to fill the FIFO and exercise backpressure.
    for (int i = 0; i < 6; i++)
      step(1, 5'(i + 1), 32'h100 + i, 1, 5'(i + 10), 32'h200 + i, 5'(i + 1));
    idle(DEPTH + 2);

    // Forwarding: two writes to rd 7, youngest wins.
    step(0, 0, 0, 1, 5'd7, 32'hA, 0);
    step(0, 0, 0, 1, 5'd7, 32'hB, 5'd7);
    step(0, 0, 0, 0, 0, 0, 5'd7);
    idle(3);
    step(0, 0, 0, 0, 0, 0, 5'd7);

    // Run the tag through its wrap with a steady stream of writes.
    for (int i = 0; i < 260; i++)
      step(0, 0, 0, 1, 5'(1 + i % 31), 32'(i), 0);
    idle(2);

    // Reset with entries still queued.
    for (int i = 0; i < 3; i++)
      step(1, 5'(i + 1), 32'h300 + i, 1, 5'(i + 4), 32'h400 + i, 0);
    do_reset();
    idle(3);

    // Randomized traffic with frequent x0 writes and backpressure.
    for (int i = 0; i < 1500; i++) begin
      logic [4:0] mi, ei;
      mi = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ei = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      step(1'($urandom_range(0, 1)), mi, $urandom(),
           1'($urandom_range(0, 1)), ei, $urandom(),
           5'($urandom_range(0, 31)));
      if (i == 700) do_reset();
    end
    idle(DEPTH + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_writeback.md
Name: cpu_writeback

Overview:
- Initiator side of the tag-change register-file write interface.
- Collects retired results from the execute unit and the memory/load unit into a small in-order FIFO.
- Drains the FIFO one write per cycle by presenting rd index and value, then advancing the write tag.
- The register file commits a write whenever it sees o_write_tag differ from its last-latched tag. This block owns that tag sequence.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- TAG_WIDTH, 8, width of o_write_tag; must equal the register file's `TAG_SIZE width.

Ports:
- i_reset  in  1  asynchronous, active-high reset
- i_clock  in  1  clock; all state on rising edge
- i_ex_valid  in  1  execute result offered
- o_ex_ready  out  1  execute result accepted this cycle when i_ex_valid=1
- i_ex_rd_idx  in  5  execute destination register
- i_ex_rd  in  32  execute result value
- i_mem_valid  in  1  load result offered
- o_mem_ready  out  1  load result accepted this cycle when i_mem_valid=1
- i_mem_rd_idx  in  5  load destination register
- i_mem_rd  in  32  load result value
- o_write_tag  out  TAG_WIDTH  write request tag; a change means a new write
- o_write_rd_idx  out  5  destination of current write
- o_rd  out  32  value of current write
- o_busy  out  1  FIFO non-empty or an issue occurred last edge; used by hazard logic

Behaviour:
- Reset (asynchronous, active-high):
  - o_write_tag=0, o_write_rd_idx=0, o_rd=0.
  - FIFO count=0, read and write pointers=0.
  - o_busy=0, o_ex_ready=1, o_mem_ready=1.
  - A reset mid-drain discards all queued entries; no tag change follows reset.
- Readiness (combinational from registered count):
  - o_mem_ready = (count < DEPTH).
  - o_ex_ready = (count < DEPTH-1) when i_mem_valid=1, otherwise (count < DEPTH).
  - Memory has priority for the last free slot.
  - Readiness ignores a same-cycle pop; this is conservative and intended.
- Enqueue at a rising edge:
  - Accepted entries are written at the write pointer.
  - When both sources are accepted in the same cycle, the memory entry goes first, then the execute entry.
  - rd_idx=0 entries are accepted (ready honoured) but never written to the FIFO. They occupy no slot and cause no tag change.
- Issue:
  - On any edge where count>0 at the start of the cycle, pop the head:
    - o_write_rd_idx and o_rd ← head fields.
    - o_write_tag ← o_write_tag+1, modulo 2^TAG_WIDTH; wrap 255→0 is legal because it is still a change.
  - At most one issue per edge.
  - An entry enqueued at edge E issues no earlier than edge E+1. The register file commits it at edge E+2.
  - Outputs hold their values between issues; the tag never changes without a pop.
- Simultaneous enqueue and pop in one edge: count' = count + accepted_nonzero − 1.
- FIFO order: strict, with memory-before-execute within a cycle. Two writes to the same rd issue in arrival order, so the later one wins.
- o_busy: registered; 1 if count'>0 or an issue happened this edge, so it covers the register-file commit cycle.
- Count is never allowed beyond DEPTH. An overflow attempt cannot occur by construction; verification asserts this.

Optional Feature:
- Macro: WRITEBACK_FORWARD_EN.
- Defined:
  - Adds ports i_fwd_rs_idx (in, 5), o_fwd_hit (out, 1), o_fwd_value (out, 32). All are combinational.
  - The search covers FIFO entries plus the last-issued entry while its commit is pending (one cycle after issue).
  - The youngest match on i_fwd_rs_idx wins.
  - i_fwd_rs_idx=0 always gives hit=0 and value=0.
- Not defined: these ports are absent; decode stalls on o_busy instead.

Test Plan:
- Reset release, then single ex result rd=5, value 0xDEADBEEF → one edge later o_write_tag 0→1, o_write_rd_idx=5, o_rd=0xDEADBEEF; o_busy falls two edges after accept.
- Same cycle: mem rd=3 value 0x11 and ex rd=3 value 0x22 → tags 1 then 2 on consecutive edges, issued in order 0x11 then 0x22; final write is 0x22.
- ex rd=0 value 0x1234 with valid held 1 cycle → o_ex_ready=1, no tag change, o_busy stays 0.
- Fill with DEPTH=4 back-to-back pairs → o_ex_ready drops at count=3 while mem valid; o_mem_ready drops at count=4; no entry lost; exactly N tag increments for N nonzero accepts.
- Preload o_write_tag to 0xFF via 255 writes, then one more → tag wraps to 0x00 and that write is committed.
- WRITEBACK_FORWARD_EN: queue rd=7 value 0xA, then rd=7 value 0xB; i_fwd_rs_idx=7 → hit=1, value 0xB. Once both are committed, hit=0. Assert reset mid-queue → hit=0 and tag=0 immediately.
